// File: rtl/bpred_pkg.sv
// Shared types and saturating-counter helpers for the bimodal direction table.
// The entry layout here matches the default table geometry.
package bpred_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  localparam int BP_IDX_W = 12;
  localparam int BP_CTR_W = 2;
  localparam logic [BP_CTR_W-1:0] BP_INIT_VAL = 2'b01;

  // Helpers work on a fixed 8-bit carrier; callers cast to their counter width.
  localparam int SAT_W = 8;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic [BP_CTR_W-1:0] data;
  } upd_entry_t;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                input logic [SAT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] v);
    return (v == '0) ? '0 : v - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] v,
                                                 input logic             taken,
                                                 input logic [SAT_W-1:0] max_v);
    return taken ? sat_inc(v, max_v) : sat_dec(v);
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Small update queue with head/tail visibility and in-place tail overwrite,
// used to coalesce repeated updates to the same table entry.
module bpred_upd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 14,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             tail_wr,
  input  logic [W-1:0]     tail_wdata,
  output logic [W-1:0]     head_data,
  output logic [W-1:0]     tail_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] tail_ptr;

  // Depth is a power of two, so the pointers wrap naturally.
  assign tail_ptr  = wr_ptr - PTR_W'(1);
  assign head_data = mem[rd_ptr];
  assign tail_data = mem[tail_ptr];
  assign empty     = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only read once the
  // occupancy count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end else if (tail_wr) begin
      mem[tail_ptr] <= tail_wdata;
    end
  end

endmodule

// File: rtl/bpred_table_update_ctrl.sv
// Sequences all writes into the bimodal direction table: an initial/requested
// sweep to INIT_VAL, then draining of coalesced execute-stage updates.
module bpred_table_update_ctrl
  import bpred_pkg::*;
#(
  parameter  int               IDX_W      = 12,
  parameter  int               CTR_W      = 2,
  parameter  int               FIFO_DEPTH = 4,
  parameter  logic [CTR_W-1:0] INIT_VAL   = CTR_W'(BP_INIT_VAL),
  localparam int               CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reinit,
  input  logic             stall,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [CTR_W-1:0] upd_ctr,
  input  logic             upd_taken,
  output logic             upd_ready,
  input  logic             lu_valid,
  input  logic [IDX_W-1:0] lu_index,
  output logic             tbl_wren,
  output logic [IDX_W-1:0] tbl_wraddr,
  output logic [CTR_W-1:0] tbl_wdata,
  output logic             init_done,
  output logic [CNT_W-1:0] q_count,
  output logic             q_overflow
);

  localparam int               ENT_W   = IDX_W + CTR_W;
  localparam logic [SAT_W-1:0] CTR_MAX = SAT_W'((2 ** CTR_W) - 1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] data;
  } entry_t;

  function automatic logic [CTR_W-1:0] next_ctr(input logic [CTR_W-1:0] cur,
                                                input logic             taken);
    return CTR_W'(sat_step(SAT_W'(cur), taken, CTR_MAX));
  endfunction

  ctrl_state_e      state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             ovf_q, ovf_d;

  entry_t           head, tail, push_entry, tail_new;
  logic             q_empty;
  logic             in_run;
  logic             accept, coalesce, push, pop;
  logic             tail_popping, lu_hit;

  assign in_run    = (state_q == RUN);
  assign init_done = in_run;
  assign upd_ready = in_run & (q_count < CNT_W'(FIFO_DEPTH));
  assign q_overflow = ovf_q;

  // Drain the head unless fetch is stalled or is reading the same entry.
  assign lu_hit = lu_valid & (lu_index == head.idx);
  assign pop    = in_run & !q_empty & !stall & !lu_hit;

  // A repeat of the tail index folds into the tail, using the queued value
  // as the fresher counter; a tail that is leaving this cycle cannot be folded.
  assign accept       = upd_valid & upd_ready;
  assign tail_popping = pop & (q_count == CNT_W'(1));
  assign coalesce     = accept & !q_empty & (tail.idx == upd_index) & !tail_popping;
  assign push         = accept & !coalesce;

  assign push_entry = '{idx: upd_index, data: next_ctr(upd_ctr, upd_taken)};
  assign tail_new   = '{idx: tail.idx,  data: next_ctr(tail.data, upd_taken)};

  bpred_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (reinit),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .tail_wr    (coalesce),
    .tail_wdata (tail_new),
    .head_data  (head),
    .tail_data  (tail),
    .count      (q_count),
    .empty      (q_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      sweep_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every next-state signal gets a default first so no path through
  // this block leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == '1) state_d = RUN;
      end
      RUN: begin
        sweep_d = '0;
        if (upd_valid && !upd_ready) ovf_d = 1'b1;
      end
      default: state_d = INIT;
    endcase
    if (reinit) begin
      state_d = INIT;
      sweep_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // Write port is forced idle while reset is held, independent of the clock.
  always_comb begin
    tbl_wren   = 1'b0;
    tbl_wraddr = '0;
    tbl_wdata  = '0;
    if (reset) begin
      if (state_q == INIT) begin
        tbl_wren   = 1'b1;
        tbl_wraddr = sweep_q;
        tbl_wdata  = INIT_VAL;
      end else begin
        tbl_wren   = pop;
        tbl_wraddr = head.idx;
        tbl_wdata  = head.data;
      end
    end
  end

endmodule
